// File: rtl/sha512_msg_schedule.sv
// ---------------------------------------------------------------------------
// sha512_msg_schedule
//
// SHA-512 message schedule generator. A 1024-bit block arrives as 32 x 32-bit
// big-endian words, one per valid/ready handshake. Word pairs are packed into
// 64-bit words W[0..15] held in a 16-entry shift window. The block then emits
// W[0..79], one word per cycle, with no gaps. The window shifts each cycle and
// the recurrence appends W[t+16].
//
// Ports
//   clk           sole clock, rising edge
//   reset         synchronous, active-high
//   word_valid_i  word_i carries a message word this cycle
//   word_i        32-bit message word, block order 0..31
//   word_ready_o  a word is accepted this cycle (LOAD state)
//   w_valid_o     w_o/round_o are valid (SCHED state)
//   w_o           schedule word W[round_o], 0 when not valid
//   round_o       round index 0..79, 0 when not valid
//   done_o        W[79] is on w_o this cycle
//   load_cnt_o    words accepted so far in the current block
// ---------------------------------------------------------------------------
module sha512_msg_schedule (
  input  logic        clk,
  input  logic        reset,
  input  logic        word_valid_i,
  input  logic [31:0] word_i,
  output logic        word_ready_o,
  output logic        w_valid_o,
  output logic [63:0] w_o,
  output logic [6:0]  round_o,
  output logic        done_o,
  output logic [4:0]  load_cnt_o
);

  typedef enum logic {
    ST_LOAD  = 1'b0,
    ST_SCHED = 1'b1
  } state_e;

  localparam logic [6:0] LAST_ROUND = 7'd79;
  localparam logic [4:0] LAST_WORD  = 5'd31;

  state_e      state_q,    state_d;
  logic [4:0]  load_cnt_q, load_cnt_d;
  logic [6:0]  round_q,    round_d;
  logic [31:0] hi_q,       hi_d;
  logic [63:0] win_q [0:15];
  logic [63:0] win_d [0:15];

  logic        accept;
  logic [63:0] new_w;

  function automatic logic [63:0] rotr(input logic [63:0] x, input int unsigned n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic logic [63:0] sigma0(input logic [63:0] x);
    return rotr(x, 1) ^ rotr(x, 8) ^ (x >> 7);
  endfunction

  function automatic logic [63:0] sigma1(input logic [63:0] x);
    return rotr(x, 19) ^ rotr(x, 61) ^ (x >> 6);
  endfunction

  // Window entry i holds W[t+i] during round t, so the recurrence taps are
  // fixed positions: W[t+14], W[t+9], W[t+1], W[t]. Carry out is dropped.
  assign new_w  = sigma1(win_q[14]) + win_q[9] + sigma0(win_q[1]) + win_q[0];
  assign accept = (state_q == ST_LOAD) && word_valid_i;

  always_comb begin
    // NOTE: every *_d gets a default before any branch, so no path leaves a
    // variable unassigned and no latch is inferred.
    state_d    = state_q;
    load_cnt_d = load_cnt_q;
    round_d    = round_q;
    hi_d       = hi_q;
    win_d      = win_q;

    unique case (state_q)
      ST_LOAD: begin
        if (accept) begin
          // 5-bit counter wraps 31 -> 0 naturally on the last word.
          load_cnt_d = load_cnt_q + 5'd1;
          if (!load_cnt_q[0]) begin
            // Even word: park it as the upper half of the next W[k].
            hi_d = word_i;
          end else begin
            // Odd word completes W[k]; shifting it in leaves W[0] at entry 0
            // once all 16 words have arrived.
            for (int i = 0; i < 15; i++) win_d[i] = win_q[i+1];
            win_d[15] = {hi_q, word_i};
          end
          if (load_cnt_q == LAST_WORD) begin
            state_d = ST_SCHED;
            round_d = 7'd0;
          end
        end
      end

      ST_SCHED: begin
        for (int i = 0; i < 15; i++) win_d[i] = win_q[i+1];
        win_d[15] = new_w;
        if (round_q == LAST_ROUND) begin
          state_d = ST_LOAD;
          round_d = 7'd0;
        end else begin
          round_d = round_q + 7'd1;
        end
      end

      default: state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_LOAD;
      load_cnt_q <= 5'd0;
      round_q    <= 7'd0;
      hi_q       <= 32'd0;
      // NOTE: the window is a register array, not a RAM, so it can and must be
      // cleared here; a reset then leaves no stale schedule words behind.
      for (int i = 0; i < 16; i++) win_q[i] <= 64'd0;
    end else begin
      // NOTE: non-blocking assignments for all state, so every flop samples
      // the pre-edge values regardless of statement order.
      state_q    <= state_d;
      load_cnt_q <= load_cnt_d;
      round_q    <= round_d;
      hi_q       <= hi_d;
      win_q      <= win_d;
    end
  end

  // Outputs decode directly from flops, so they are glitch-free at the edge.
  assign word_ready_o = (state_q == ST_LOAD);
  assign w_valid_o    = (state_q == ST_SCHED);
  assign w_o          = w_valid_o ? win_q[0] : 64'd0;
  assign round_o      = w_valid_o ? round_q  : 7'd0;
  assign done_o       = w_valid_o && (round_q == LAST_ROUND);
  assign load_cnt_o   = load_cnt_q;

endmodule

// File: tb/tb_sha512_msg_schedule.sv
// ---------------------------------------------------------------------------
// tb_sha512_msg_schedule
//
// Directed bench for sha512_msg_schedule. The driver pushes the full expected
// W[0..79] sequence of each complete block into a queue. A monitor on the
// falling edge pops the queue and compares each valid schedule word. Driver
// side checks run 1 ns after the rising edge.
// ---------------------------------------------------------------------------
module tb_sha512_msg_schedule;

  logic        clk = 1'b0;
  logic        reset;
  logic        word_valid_i;
  logic [31:0] word_i;
  logic        word_ready_o;
  logic        w_valid_o;
  logic [63:0] w_o;
  logic [6:0]  round_o;
  logic        done_o;
  logic [4:0]  load_cnt_o;

  sha512_msg_schedule dut (
    .clk          (clk),
    .reset        (reset),
    .word_valid_i (word_valid_i),
    .word_i       (word_i),
    .word_ready_o (word_ready_o),
    .w_valid_o    (w_valid_o),
    .w_o          (w_o),
    .round_o      (round_o),
    .done_o       (done_o),
    .load_cnt_o   (load_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] w;
    logic [6:0]  round;
    logic        done;
  } exp_t;

  exp_t sb_q[$];
  int   tests_run    = 0;
  int   tests_failed = 0;
  bit   b2b_check    = 1'b0;
  bit   done_seen    = 1'b0;
  bit   prev_done    = 1'b0;
  int   gap_cnt      = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model, written from the recurrence over a flat W[] array.
  function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic logic [63:0] s0(input logic [63:0] x);
    return rotr(x, 1) ^ rotr(x, 8) ^ (x >> 7);
  endfunction

  function automatic logic [63:0] s1(input logic [63:0] x);
    return rotr(x, 19) ^ rotr(x, 61) ^ (x >> 6);
  endfunction

  task automatic push_expected(input logic [31:0] wd [32]);
    logic [63:0] w [80];
    exp_t        e;
    for (int k = 0; k < 16; k++) w[k] = {wd[2*k], wd[2*k+1]};
    for (int t = 16; t < 80; t++) w[t] = s1(w[t-2]) + w[t-7] + s0(w[t-15]) + w[t-16];
    for (int t = 0; t < 80; t++) begin
      e.w     = w[t];
      e.round = 7'(t);
      e.done  = (t == 79);
      sb_q.push_back(e);
    end
  endtask

  // Monitor: compares the schedule stream and idle outputs on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      prev_done = 1'b0;
      done_seen = 1'b0;
      gap_cnt   = 0;
    end else begin
      check("ready_is_not_valid", word_ready_o, !w_valid_o);
      if (prev_done) begin
        check("ready_after_done", word_ready_o, 1);
        check("load_cnt_after_done", load_cnt_o, 0);
      end
      if (w_valid_o) begin
        if (b2b_check && done_seen && round_o == 7'd0) check("b2b_load_gap", gap_cnt, 32);
        if (sb_q.size() == 0) begin
          check("unexpected_w_valid", w_valid_o, 0);
        end else begin
          e = sb_q.pop_front();
          check($sformatf("w[%0d]", e.round), w_o, e.w);
          check($sformatf("round[%0d]", e.round), round_o, e.round);
          check($sformatf("done[%0d]", e.round), done_o, e.done);
        end
      end else begin
        check("idle_w_zero", w_o, 0);
        check("idle_round_zero", round_o, 0);
        check("idle_done_zero", done_o, 0);
        gap_cnt++;
      end
      if (done_o) begin
        done_seen = 1'b1;
        gap_cnt   = 0;
      end
      prev_done = done_o;
    end
  end

  // Driver tasks: all start and end 1 ns after a rising edge.
  task automatic do_reset();
    reset        = 1'b1;
    word_valid_i = 1'b1;   // reset must win over a simultaneous word
    word_i       = 32'h1234_5678;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", word_ready_o, 1);
    check("rst_w_valid", w_valid_o, 0);
    check("rst_w", w_o, 0);
    check("rst_round", round_o, 0);
    check("rst_done", done_o, 0);
    check("rst_load_cnt", load_cnt_o, 0);
    sb_q.delete();
    word_valid_i = 1'b0;
    word_i       = 32'd0;
    reset        = 1'b0;
  endtask

  task automatic send_words(input logic [31:0] wd [32], input int n, input bit gap,
                            input bit hold_ff);
    if (n == 32) push_expected(wd);
    for (int i = 0; i < n; i++) begin
      if (gap && i > 0) begin
        word_valid_i = 1'b0;
        word_i       = 32'hA5A5_A5A5;
        @(posedge clk);
        #1;
      end
      check($sformatf("load_cnt_before_word%0d", i), load_cnt_o, i);
      word_valid_i = 1'b1;
      word_i       = wd[i];
      @(posedge clk);
      #1;
    end
    word_valid_i = hold_ff;
    word_i       = hold_ff ? 32'hFFFF_FFFF : 32'd0;
    if (n == 32) begin
      check("sched_entry_valid", w_valid_o, 1);
      check("sched_entry_round", round_o, 0);
      check("sched_entry_ready", word_ready_o, 0);
    end
  endtask

  task automatic wait_done();
    bit found = 1'b0;
    for (int n = 0; n < 120 && !found; n++) begin
      if (done_o) found = 1'b1;
      @(posedge clk);
      #1;
    end
    word_valid_i = 1'b0;
    word_i       = 32'd0;
    check("done_seen_in_budget", found, 1);
    check("ready_next_block", word_ready_o, 1);
    check("load_cnt_next_block", load_cnt_o, 0);
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ramp [32];
    logic [31:0] abc  [32];
    bit          hit;

    for (int i = 0; i < 32; i++) begin
      ramp[i] = 32'hDEAD_0000 + 32'(i);
      abc[i]  = 32'd0;
    end
    abc[0]  = 32'h6162_6380;
    abc[31] = 32'h0000_0018;

    reset        = 1'b1;
    word_valid_i = 1'b0;
    word_i       = 32'd0;
    do_reset();

    // Ramp block, one word per cycle.
    send_words(ramp, 32, 1'b0, 1'b0);
    wait_done();

    // Ramp block with an idle cycle between words.
    send_words(ramp, 32, 1'b1, 1'b0);
    wait_done();

    // All-ones words offered during SCHED are ignored, then a clean abc block.
    send_words(ramp, 32, 1'b0, 1'b1);
    wait_done();
    send_words(abc, 32, 1'b0, 1'b0);
    wait_done();

    // Reset after 20 words drops the partial block.
    send_words(ramp, 20, 1'b0, 1'b0);
    check("partial_load_cnt", load_cnt_o, 20);
    do_reset();
    send_words(ramp, 32, 1'b0, 1'b0);
    wait_done();

    // Reset during round 40 aborts the schedule.
    send_words(ramp, 32, 1'b0, 1'b0);
    hit = 1'b0;
    for (int n = 0; n < 60 && !hit; n++) begin
      if (round_o == 7'd40) hit = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    check("reached_round40", hit, 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("abort_w_valid", w_valid_o, 0);
    check("abort_ready", word_ready_o, 1);
    check("abort_load_cnt", load_cnt_o, 0);
    sb_q.delete();
    reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("abort_stays_idle", w_valid_o, 0);

    // Back-to-back blocks: abc then ramp, 32 load cycles between streams.
    do_reset();
    b2b_check = 1'b1;
    send_words(abc, 32, 1'b0, 1'b0);
    wait_done();
    send_words(ramp, 32, 1'b0, 1'b0);
    wait_done();
    b2b_check = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
